result_stream_packetizer: RTL and testbench
===========================================

# result_stream_packetizer

Decoder-side transmitter for the 32-bit result stream leaving a leaf FPGA toward the host-side output FIFO. It times each decoding round with an internal cycle counter. On round completion it emits one packet: a header word {8'h00, iteration[7:0], cycles[15:0]}, then the round's correction words pulled from an upstream source, then the terminator 32'hFFFFFFFF. It is the producing end of the stream that the host and bench consume word-by-word until the terminator.

## Interface
- CYCLE_WIDTH, 16, width of internal round cycle counter; saturates at all-ones.
- ITER_WIDTH, 8, width of iteration count field (≤8).
- COUNT_WIDTH, 16, width of correction-word count.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- round_start  in  1  pulse: clustering of a new round begins.
- round_done  in  1  pulse: round finished; latches iteration_count and corr_count.
- iteration_count  in  ITER_WIDTH  iterations used by the round.
- corr_count  in  COUNT_WIDTH  number of correction words to pull for this round.
- corr_data  in  32  correction word from upstream.
- corr_valid  in  1  corr_data valid.
- corr_ready  out  1  consumes corr_data; reset 0.
- out_data  out  32  stream word; reset 0.
- out_valid  out  1  stream word valid; reset 0.
- out_ready  in  1  downstream accepts.
- idle  out  1  packetizer in IDLE; reset 1.
- overrun  out  1  sticky: round_done seen while not IDLE; reset 0.
- bad_word  out  1  sticky: reserved word 32'hFFFFFFFF received as correction; reset 0.

## Operation
- Cycle counter: cleared to 0 on round_start and then increments each cycle until round_done, saturating at 2^CYCLE_WIDTH-1. It runs independently of the emitter. round_start and round_done in the same cycle: the counter clears, and the packet reports cycles=0.
- States: IDLE, HEADER, BODY, (COUNT), TRAILER.
- IDLE: on round_done, latch cycles, iteration_count, and corr_count (remaining=corr_count), then go to HEADER.
- HEADER: load out_data={8'h00, iteration, cycles[15:0]}. Cycle bits above 15 are saturated into 16'hFFFF when CYCLE_WIDTH>16, and zero-extended when narrower. Then go to BODY, or go directly to TRAILER (or COUNT) if remaining==0.
- BODY: corr_ready=1 only when the output register is free (out_valid==0, or out_ready==1). Each accepted corr_data decrements remaining.
  - Accepted word ≠ FFFFFFFF: it becomes the next out_data.
  - Accepted word == FFFFFFFF: dropped, no output beat, and bad_word is set.
  - Leave BODY when remaining reaches 0.
- TRAILER: emit 32'hFFFFFFFF, then return to IDLE once it is accepted.
- round_done outside IDLE: ignored, overrun set, and the in-flight packet is unaffected.
- Sticky flags clear only on reset.
- Reset mid-packet: all state is discarded, outputs return to reset values, and no trailer is emitted.

## Timing
- Output is a single register stage. out_data is held stable while out_valid=1 and out_ready=0.
- out_valid never drops without acceptance.
- round_done at edge N: idle falls at N+1 and the header is valid at N+1.
- With out_ready=1 and corr_valid=1 continuously, a packet takes corr_count+2 cycles (header, body, trailer), plus 1 cycle with the COUNT word. Sustained rate is one beat per cycle.
- corr_ready is combinational from state, out_valid, and out_ready. A correction is transferred only when corr_valid and corr_ready are both 1.
- idle rises the cycle after the trailer is accepted. A round_done in that same cycle is accepted, so back-to-back packets are separated by 1 idle cycle.

## Configuration
- RESULT_PKT_COUNT_EN defined:
  - COUNT state is present; after BODY the block emits {16'h0, emitted_count[15:0]} before the trailer.
  - emitted_count is the number of body words actually output, excluding dropped reserved words.
- Undefined: COUNT state is absent, and BODY/HEADER go straight to TRAILER.

## Test plan
- round_start, then round_done 37 cycles later with iteration=3, corr_count=2 (words 0x00010203, 0x00020304), out_ready=1 → stream 0x0003_0025, 0x00010203, 0x00020304, FFFFFFFF; idle returns.
- corr_count=0, iteration=1, cycles=5 → exactly 2 beats: 0x00010005, FFFFFFFF; corr_ready never asserted.
- out_ready toggled 1/0 every cycle and corr_valid randomly gapped, corr_count=4 → each word is held stable while stalled, order is preserved, no duplicates, and the 6 beats total are correct.
- Corrections are 0x11, FFFFFFFF, 0x22 (corr_count=3) → output is header, 0x11, 0x22, FFFFFFFF, and bad_word=1. With RESULT_PKT_COUNT_EN a 0x00000002 word precedes the trailer.
- Second round_done while in BODY → overrun=1; the first packet completes intact, and no second packet appears.
- round_start with no round_done for 70000 cycles, then done → cycle field 0xFFFF. Reset asserted mid-BODY → out_valid=0, idle=1, and both flags=0 the next cycle.

Source files
------------

// File: rtl/result_stream_packetizer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// result_stream_packetizer
//
// Purpose
//   This is the transmitter for the 32-bit result stream of a leaf FPGA. An
//   internal counter times each decoding round. When a round completes, the
//   block emits one packet:
//     1. header    {8'h00, iteration[7:0], cycles[15:0]}
//     2. body      the round's correction words, pulled from an upstream source
//     3. [count]   {16'h0, emitted_count[15:0]}, only when RESULT_PKT_COUNT_EN
//                  is defined
//     4. trailer   32'hFFFFFFFF
//   A correction word equal to 32'hFFFFFFFF would look like an early trailer.
//   Such a word is consumed and dropped, and the bad_word flag is set.
//
// Build option
//   RESULT_PKT_COUNT_EN : when defined, a COUNT state emits the number of body
//                         words actually sent, placed just before the trailer.
//
// Parameters
//   CYCLE_WIDTH  width of the round cycle counter (saturating)
//   ITER_WIDTH   width of iteration_count (<= 8)
//   COUNT_WIDTH  width of corr_count
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   round_start      pulse: clears the cycle counter and starts it running
//   round_done       pulse: stops the counter; in IDLE it launches a packet
//   iteration_count  iterations used by the round (sampled with round_done)
//   corr_count       correction words to pull (sampled with round_done)
//   corr_data/valid  upstream correction word stream
//   corr_ready       upstream handshake (combinational)
//   out_data/valid   registered output stream word
//   out_ready        downstream handshake
//   idle             high while no packet is in progress
//   overrun          sticky: round_done arrived while a packet was in progress
//   bad_word         sticky: a reserved 32'hFFFFFFFF arrived as a correction
// -----------------------------------------------------------------------------
module result_stream_packetizer #(
    parameter int CYCLE_WIDTH = 16,
    parameter int ITER_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   round_start,
    input  logic                   round_done,
    input  logic [ITER_WIDTH-1:0]  iteration_count,
    input  logic [COUNT_WIDTH-1:0] corr_count,
    input  logic [31:0]            corr_data,
    input  logic                   corr_valid,
    output logic                   corr_ready,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   idle,
    output logic                   overrun,
    output logic                   bad_word
);

    localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

    // The header is not a separate state. It is loaded into the output
    // register on the same edge that leaves IDLE. This lets the header become
    // valid one cycle after round_done.
    //   S_BODY    : pull correction words until remaining reaches 0
    //   S_COUNT   : load the emitted-count word when the output register frees
    //   S_TRAILER : load the terminator when the output register frees
    //   S_LAST    : terminator in flight; return to IDLE once it is accepted
`ifdef RESULT_PKT_COUNT_EN
    typedef enum logic [2:0] {S_IDLE, S_BODY, S_COUNT, S_TRAILER, S_LAST} state_t;
    localparam state_t S_POST_BODY = S_COUNT;
`else
    typedef enum logic [2:0] {S_IDLE, S_BODY, S_TRAILER, S_LAST} state_t;
    localparam state_t S_POST_BODY = S_TRAILER;
`endif

    // -------------------------------------------------------------------------
    // Round cycle counter
    // -------------------------------------------------------------------------
    // This counter runs independently of the emitter. The header samples
    // cyc_d rather than cyc_q, so the cycles field counts the round_done edge
    // itself. If round_start and round_done arrive together, the counter
    // clears and the field reads 0.
    logic [CYCLE_WIDTH-1:0] cyc_q, cyc_d;
    logic                   run_q, run_d;

    always_comb begin
        cyc_d = cyc_q;
        run_d = run_q;
        if (round_start) begin
            cyc_d = '0;
            run_d = 1'b1;
        end else if (run_q && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYCLE_WIDTH'(1);
        end
        if (round_done) begin
            run_d = 1'b0;
        end
    end

    // The header field is 16 bits wide. A wider counter saturates into 16'hFFFF
    // when any upper bit is set. A narrower counter is zero-extended.
    logic [15:0] cyc_field;

    generate
        if (CYCLE_WIDTH > 16) begin : g_cyc_sat
            assign cyc_field = (|cyc_d[CYCLE_WIDTH-1:16]) ? 16'hFFFF : cyc_d[15:0];
        end else if (CYCLE_WIDTH == 16) begin : g_cyc_eq
            assign cyc_field = cyc_d;
        end else begin : g_cyc_ext
            assign cyc_field = {{(16-CYCLE_WIDTH){1'b0}}, cyc_d};
        end
    endgenerate

    // The iteration field is zero-extended to 8 bits.
    logic [7:0] iter_field;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_iter
            if (gi < ITER_WIDTH) begin : g_bit
                assign iter_field[gi] = iteration_count[gi];
            end else begin : g_zero
                assign iter_field[gi] = 1'b0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Emitter state
    // -------------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [31:0]            out_data_q,  out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q,   overrun_d;
    logic                   bad_word_q,  bad_word_d;
`ifdef RESULT_PKT_COUNT_EN
    logic [15:0]            emitted_q,   emitted_d;
`endif

    logic out_free;
    logic corr_accept;

    always_comb begin
        // The single output register can take a new word when it is empty or
        // when its current word is being accepted in this cycle.
        out_free    = !out_valid_q || out_ready;
        corr_ready  = (state_q == S_BODY) && out_free;
        corr_accept = corr_ready && corr_valid;

        state_d     = state_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        overrun_d   = overrun_q || (round_done && (state_q != S_IDLE));
        bad_word_d  = bad_word_q;
`ifdef RESULT_PKT_COUNT_EN
        emitted_d   = emitted_q;
`endif

        case (state_q)
            S_IDLE: begin
                // When the packet enters IDLE, the output register is already
                // empty, because the trailer was accepted. The header can
                // therefore load right away.
                if (round_done) begin
                    out_data_d  = {8'h00, iter_field, cyc_field};
                    out_valid_d = 1'b1;
                    remaining_d = corr_count;
`ifdef RESULT_PKT_COUNT_EN
                    emitted_d   = '0;
`endif
                    state_d     = (corr_count == '0) ? S_POST_BODY : S_BODY;
                end
            end

            S_BODY: begin
                if (corr_accept) begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (corr_data == TERM_WORD) begin
                        // A reserved word is dropped, and no output beat is
                        // produced for it.
                        bad_word_d = 1'b1;
                    end else begin
                        out_data_d  = corr_data;
                        out_valid_d = 1'b1;
`ifdef RESULT_PKT_COUNT_EN
                        emitted_d   = emitted_q + 16'd1;
`endif
                    end
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = S_POST_BODY;
                    end
                end
            end

`ifdef RESULT_PKT_COUNT_EN
            S_COUNT: begin
                if (out_free) begin
                    out_data_d  = {16'h0000, emitted_q};
                    out_valid_d = 1'b1;
                    state_d     = S_TRAILER;
                end
            end
`endif

            S_TRAILER: begin
                if (out_free) begin
                    out_data_d  = TERM_WORD;
                    out_valid_d = 1'b1;
                    state_d     = S_LAST;
                end
            end

            S_LAST: begin
                // In this state, out_valid_q is always set. The trailer leaves
                // when out_ready is high.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q       <= '0;
            run_q       <= 1'b0;
            state_q     <= S_IDLE;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            bad_word_q  <= 1'b0;
`ifdef RESULT_PKT_COUNT_EN
            emitted_q   <= '0;
`endif
        end else begin
            cyc_q       <= cyc_d;
            run_q       <= run_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            bad_word_q  <= bad_word_d;
`ifdef RESULT_PKT_COUNT_EN
            emitted_q   <= emitted_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign idle      = (state_q == S_IDLE);
    assign overrun   = overrun_q;
    assign bad_word  = bad_word_q;

endmodule

// File: tb/tb_result_stream_packetizer.sv
`timescale 1ns/1ps
// Testbench for result_stream_packetizer.
// Expected packets are pushed to a scoreboard queue when a round is launched.
// A negedge monitor pops and compares each accepted output beat.
module tb_result_stream_packetizer;

    localparam logic [31:0] TERM = 32'hFFFF_FFFF;
`ifdef RESULT_PKT_COUNT_EN
    localparam int CNT_EXTRA = 1;
`else
    localparam int CNT_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        round_start;
    logic        round_done;
    logic [7:0]  iteration_count;
    logic [15:0] corr_count;
    logic [31:0] corr_data;
    logic        corr_valid;
    logic        corr_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        idle;
    logic        overrun;
    logic        bad_word;

    always #5 clk = ~clk;

    result_stream_packetizer dut (
        .clk             (clk),
        .reset           (reset),
        .round_start     (round_start),
        .round_done      (round_done),
        .iteration_count (iteration_count),
        .corr_count      (corr_count),
        .corr_data       (corr_data),
        .corr_valid      (corr_valid),
        .corr_ready      (corr_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .idle            (idle),
        .overrun         (overrun),
        .bad_word        (bad_word)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    // Scoreboard and source queues.
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];

    // Environment controls.
    bit rdy_toggle = 0;
    bit gap_mode   = 0;
    bit hold_src   = 0;

    // Monitor state.
    bit          xfer_flag = 0;
    bit          hold_pend = 0;
    logic [31:0] hold_data = '0;
    bit          term_acc  = 0;
    bit          cr_seen   = 0;
    int          beats     = 0;

    // Monitor: sample away from the active edge.
    always begin
        @(negedge clk);
        if (!reset) begin
            xfer_flag = corr_valid && corr_ready;
            if (corr_ready) cr_seen = 1;
            if (hold_pend) begin
                chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_hold_data", out_data, hold_data);
            end
            if (term_acc) chk("idle_after_trailer", {31'b0, idle}, 32'd1);
            term_acc = 0;
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", out_data);
                end else begin
                    chk("beat", out_data, exp_q.pop_front());
                end
                term_acc = (out_data == TERM);
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
        end else begin
            xfer_flag = 0;
            hold_pend = 0;
            term_acc  = 0;
        end
    end

    // Environment: downstream ready and the upstream correction source.
    always begin
        @(posedge clk);
        #1;
        if (xfer_flag && src_q.size() > 0) void'(src_q.pop_front());
        xfer_flag = 0;
        out_ready = rdy_toggle ? ~out_ready : 1'b1;
        if (!hold_src && src_q.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
            corr_valid = 1'b1;
            corr_data  = src_q[0];
        end else begin
            corr_valid = 1'b0;
            corr_data  = 32'hDEAD_BEEF;
        end
    end

    // Launch a round. round_done is sampled gap edges after round_start, so
    // the expected cycle count is gap.
    task automatic send_round(input logic [7:0] it, input logic [15:0] cnt, input int gap);
        round_start = 1'b1;
        if (gap == 0) begin
            round_done = 1'b1;
            iteration_count = it;
            corr_count = cnt;
        end
        @(posedge clk);
        #1;
        round_start = 1'b0;
        if (gap != 0) begin
            repeat (gap - 1) @(posedge clk);
            #1;
            round_done = 1'b1;
            iteration_count = it;
            corr_count = cnt;
            @(posedge clk);
            #1;
        end
        round_done = 1'b0;
        chk("hdr_latency_idle", {31'b0, idle}, 32'd0);
        chk("hdr_latency_valid", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while ((!idle || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_in_time", {31'b0, (n < 3000)}, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  iter;
        int          cnt;
        int          gap;
        logic [31:0] w[4];
        bit          tog;
        bit          gaps;
        bit          exp_bad;
        int          exp_beats;   // without the optional count word
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx, input vec_t v);
        int good;
        int b0;
        int n;
        logic [15:0] cyc;
        good = 0;
        cr_seen = 0;
        rdy_toggle = v.tog;
        gap_mode = v.gaps;
        cyc = (v.gap > 65535) ? 16'hFFFF : 16'(v.gap);
        exp_q.push_back({8'h00, v.iter, cyc});
        for (int i = 0; i < v.cnt; i++) begin
            src_q.push_back(v.w[i]);
            if (v.w[i] != TERM) begin
                exp_q.push_back(v.w[i]);
                good++;
            end
        end
`ifdef RESULT_PKT_COUNT_EN
        exp_q.push_back({16'h0000, 16'(good)});
`endif
        exp_q.push_back(TERM);
        b0 = beats;
        send_round(v.iter, 16'(v.cnt), v.gap);
        wait_done(n);
        rdy_toggle = 0;
        gap_mode = 0;
        chk("beat_count", 32'(beats - b0), 32'(v.exp_beats + CNT_EXTRA));
        chk("bad_word", {31'b0, bad_word}, {31'b0, v.exp_bad});
        chk("overrun_clear", {31'b0, overrun}, 32'd0);
        chk("src_drained", 32'(src_q.size()), 32'd0);
        chk("corr_ready_seen", {31'b0, cr_seen}, {31'b0, (v.cnt != 0)});
        if (!v.tog && !v.gaps) chk("packet_cycles", 32'(n), 32'(v.cnt + 2 + CNT_EXTRA));
        $display("pkt %0d: iter=%h cnt=%0d gap=%0d beats=%0d cycles=%0d",
                 idx, v.iter, v.cnt, v.gap, beats - b0, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b0;
        reset = 1'b1;
        round_start = 1'b0;
        round_done = 1'b0;
        iteration_count = '0;
        corr_count = '0;
        corr_data = '0;
        corr_valid = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{8'h03, 2, 37, '{32'h0001_0203, 32'h0002_0304, 32'h0, 32'h0}, 1'b0, 1'b0, 1'b0, 4};
        vecs[1] = '{8'h01, 0, 5, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 1'b0, 2};
        vecs[2] = '{8'h07, 4, 12, '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004}, 1'b1, 1'b1, 1'b0, 6};
        vecs[3] = '{8'h55, 1, 70000, '{32'h1234_5678, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 1'b0, 3};
        vecs[4] = '{8'h02, 3, 0, '{32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0022, 32'h0}, 1'b0, 1'b0, 1'b1, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_corr_ready", {31'b0, corr_ready}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_bad_word", {31'b0, bad_word}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Overrun: a second round_done while the first packet is held in BODY.
        hold_src = 1;
        exp_q.push_back({8'h00, 8'h04, 16'd4});
        for (int i = 0; i < 3; i++) begin
            src_q.push_back(32'h0000_0100 + 32'(i));
            exp_q.push_back(32'h0000_0100 + 32'(i));
        end
`ifdef RESULT_PKT_COUNT_EN
        exp_q.push_back(32'h0000_0003);
`endif
        exp_q.push_back(TERM);
        b0 = beats;
        send_round(8'h04, 16'd3, 4);
        repeat (2) @(posedge clk);
        #1;
        round_done = 1'b1;
        iteration_count = 8'h09;
        corr_count = 16'd5;
        @(posedge clk);
        #1;
        round_done = 1'b0;
        chk("overrun_set", {31'b0, overrun}, 32'd1);
        chk("overrun_not_idle", {31'b0, idle}, 32'd0);
        hold_src = 0;
        wait_done(n);
        repeat (20) @(posedge clk);
        #1;
        chk("overrun_beats", 32'(beats - b0), 32'(5 + CNT_EXTRA));
        chk("overrun_idle_after", {31'b0, idle}, 32'd1);
        chk("overrun_sticky", {31'b0, overrun}, 32'd1);
        $display("pkt overrun: beats=%0d", beats - b0);

        // Reset in the middle of BODY.
        hold_src = 1;
        exp_q.push_back({8'h00, 8'h06, 16'd3});
        src_q.push_back(32'h0000_0AAA);
        src_q.push_back(32'h0000_0BBB);
        b0 = beats;
        send_round(8'h06, 16'd2, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_in_body", {31'b0, corr_ready}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        src_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_idle", {31'b0, idle}, 32'd1);
        chk("midrst_overrun", {31'b0, overrun}, 32'd0);
        chk("midrst_bad_word", {31'b0, bad_word}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        reset = 1'b0;
        hold_src = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_trailer", 32'(beats - b0), 32'd1);
        $display("pkt reset: beats=%0d", beats - b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
